// File: rtl/spi_cmd_regfile_if.sv
// Frame handshake between the SPI slave transceiver and the command register file.
// The transceiver is the master; the register file is the slave.
interface spi_cmd_regfile_if #(
    parameter int LEN_SPI = 32
);
    logic [LEN_SPI-1:0] rx_output;
    logic               rdy_spi;
    logic               spi_busy;
    logic               ack_fetch_spi;
    logic [LEN_SPI-1:0] tx_input;
    logic               push_tx;

    modport master (
        output rx_output, rdy_spi, spi_busy,
        input  ack_fetch_spi, tx_input, push_tx
    );

    modport slave (
        input  rx_output, rdy_spi, spi_busy,
        output ack_fetch_spi, tx_input, push_tx
    );
endinterface

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder: WRITE/READ/NOP against a 16x16 register bank,
// returning a response word to the transceiver TX holding register.
module spi_cmd_regfile #(
    parameter int           LEN_SPI  = 32,
    parameter int           ADDR_W   = 4,
    parameter int           NUM_REGS = 16,
    parameter logic [15:0]  ID_VALUE = 16'hA5C3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_cmd_regfile_if.slave        spi,
    output logic [NUM_REGS*16-1:0]  cfg_regs,
    output logic                    wr_strobe,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              cmd_cnt,
    output logic [7:0]              err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        PUSH,
        WAIT_ACK
    } state_t;

    state_t state, state_nx;

    logic [LEN_SPI-1:0] cmd_q;
    logic [LEN_SPI-1:0] resp_q;
    logic [LEN_SPI-1:0] tx_q;
    logic               err_q;
    logic [15:0]        regs [1:NUM_REGS-1];

    logic [1:0]         op;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        data;
    logic               is_wr;
    logic               is_rd;
    logic               dec_err;
    logic [15:0]        rd_data;
    logic [15:0]        payload;
    logic [LEN_SPI-1:0] resp_d;

    logic               latch;
    logic               overrun;
    logic               push;
    logic               ack;
    logic               wr_en;
    logic [1:0]         err_inc;
    logic [8:0]         err_sum;

    assign op    = cmd_q[31:30];
    assign addr  = cmd_q[16 +: ADDR_W];
    assign data  = cmd_q[15:0];
    assign is_wr = (op == 2'b01);
    assign is_rd = (op == 2'b10);

    always_comb begin
        cfg_regs = '0;
        cfg_regs[15:0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++)
            cfg_regs[i*16 +: 16] = regs[i];
    end

    assign rd_data = cfg_regs[{addr, 4'h0} +: 16];

    assign dec_err = (op == 2'b11)
                   || (|cmd_q[29:16+ADDR_W])
                   || (is_wr && (addr == '0));

    always_comb begin
        payload = '0;
        if (!dec_err && is_rd)
            payload = rd_data;
        else if (!dec_err && is_wr)
            payload = data;
    end

    assign resp_d = {op, dec_err, cmd_q[28:16], payload};

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        overrun  = 1'b0;
        push     = 1'b0;
        ack      = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (spi.rdy_spi) begin
                    latch    = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                overrun  = spi.rdy_spi;
                state_nx = EXEC;
            end
            EXEC: begin
                overrun  = spi.rdy_spi;
                wr_en    = is_wr && !err_q;
                state_nx = PUSH;
            end
            PUSH: begin
                overrun = spi.rdy_spi;
                if (!spi.spi_busy) begin
                    push     = 1'b1;
                    state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A direct return to ready pre-empts the new-frame check
                if (spi.rdy_spi) begin
                    latch    = 1'b1;
                    state_nx = DECODE;
                end else if (spi.spi_busy) begin
                    state_nx = IDLE;
                end else begin
                    ack = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign err_inc = {1'b0, (state == EXEC) && err_q} + {1'b0, overrun};
    assign err_sum = {1'b0, err_cnt} + {7'd0, err_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cmd_q   <= '0;
            resp_q  <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
            wr_addr <= '0;
            cmd_cnt <= '0;
            err_cnt <= '0;
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (latch)
                cmd_q <= spi.rx_output;
            if (state == DECODE) begin
                err_q  <= dec_err;
                resp_q <= resp_d;
            end
            if (state == EXEC) begin
                tx_q <= resp_q;
                if (!err_q)
                    cmd_cnt <= cmd_cnt + 8'd1;
            end
            if (wr_en) begin
                regs[addr] <= data;
                wr_addr    <= addr;
            end
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign wr_strobe         = wr_en;
    assign spi.push_tx       = push;
    assign spi.ack_fetch_spi = ack;
    assign spi.tx_input      = tx_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile: command flow, errors, stalls,
// overrun, counter saturation and asynchronous reset.
module tb_spi_cmd_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] cfg_regs;
    logic         wr_strobe;
    logic [3:0]   wr_addr;
    logic [7:0]   cmd_cnt;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    spi_cmd_regfile_if bus ();

    spi_cmd_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (bus.slave),
        .cfg_regs  (cfg_regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .cmd_cnt   (cmd_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] frame);
        @(negedge clk);
        bus.rx_output = frame;
        bus.rdy_spi   = 1'b1;
    endtask

    // Walks DECODE, EXEC, PUSH, WAIT_ACK with spi_busy low
    task automatic follow(input logic [31:0] exp_tx, input logic exp_wr);
        @(negedge clk);
        bus.rdy_spi = 1'b0;
        #1;
        chk("dec_push", bus.push_tx, 0);
        chk("dec_wr", wr_strobe, 0);
        @(negedge clk);
        #1;
        chk("exec_wr", wr_strobe, exp_wr);
        chk("exec_push", bus.push_tx, 0);
        @(negedge clk);
        #1;
        chk("push", bus.push_tx, 1);
        chk("tx", bus.tx_input, exp_tx);
        @(negedge clk);
        #1;
        chk("ack", bus.ack_fetch_spi, 1);
        chk("push_once", bus.push_tx, 0);
        chk("tx_hold", bus.tx_input, exp_tx);
    endtask

    task automatic release_ack();
        @(negedge clk);
        bus.spi_busy = 1'b1;
        #1;
        chk("ack_drop", bus.ack_fetch_spi, 0);
        @(negedge clk);
        bus.spi_busy = 1'b0;
        #1;
        chk("idle_ack", bus.ack_fetch_spi, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.rx_output = '0;
        bus.rdy_spi   = 1'b0;
        bus.spi_busy  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", bus.tx_input, 0);
        chk("rst_push", bus.push_tx, 0);
        chk("rst_ack", bus.ack_fetch_spi, 0);
        chk("rst_cmd", cmd_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_reg0", cfg_regs[15:0], 32'hA5C3);
        chk("rst_regs", {31'd0, |cfg_regs[255:16]}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h8000_0000);
        follow(32'h8000_A5C3, 0);
        chk("cmd1", cmd_cnt, 1);
        release_ack();

        issue(32'h4005_1234);
        follow(32'h4005_1234, 1);
        chk("wr_addr5", wr_addr, 5);
        chk("reg5", cfg_regs[95:80], 32'h1234);
        chk("cmd2", cmd_cnt, 2);
        release_ack();

        issue(32'h8005_0000);
        follow(32'h8005_1234, 0);
        chk("cmd3", cmd_cnt, 3);
        release_ack();

        issue(32'h4000_FFFF);
        follow(32'h6000_0000, 0);
        release_ack();
        issue(32'hC003_0000);
        follow(32'hE003_0000, 0);
        release_ack();
        issue(32'h8010_0000);
        follow(32'hA010_0000, 0);
        release_ack();
        chk("err3", err_cnt, 3);
        chk("cmd_keep", cmd_cnt, 3);
        chk("reg0_keep", cfg_regs[15:0], 32'hA5C3);
        chk("reg5_keep", cfg_regs[95:80], 32'h1234);

        issue(32'h8005_0000);
        @(negedge clk);
        bus.rdy_spi = 1'b0;
        @(negedge clk);
        bus.spi_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_push", bus.push_tx, 0);
            chk("stall_tx", bus.tx_input, 32'h8005_1234);
        end
        @(negedge clk);
        bus.spi_busy = 1'b0;
        #1;
        chk("stall_release", bus.push_tx, 1);
        @(negedge clk);
        #1;
        chk("stall_ack", bus.ack_fetch_spi, 1);
        chk("cmd4", cmd_cnt, 4);

        issue(32'h4002_00AA);
        #1;
        chk("reentry_ack", bus.ack_fetch_spi, 0);
        follow(32'h4002_00AA, 1);
        chk("reg2", cfg_regs[47:32], 32'h00AA);
        chk("cmd5", cmd_cnt, 5);
        release_ack();

        issue(32'h8001_0000);
        @(negedge clk);
        bus.rdy_spi = 1'b0;
        @(negedge clk);
        bus.rx_output = 32'h4003_5555;
        bus.rdy_spi   = 1'b1;
        @(negedge clk);
        bus.rdy_spi = 1'b0;
        #1;
        chk("ovr_push", bus.push_tx, 1);
        chk("ovr_tx", bus.tx_input, 32'h8001_0000);
        @(negedge clk);
        #1;
        chk("ovr_ack", bus.ack_fetch_spi, 1);
        chk("ovr_err", err_cnt, 4);
        chk("ovr_cmd", cmd_cnt, 6);
        chk("ovr_reg3", cfg_regs[63:48], 0);
        release_ack();

        for (int i = 0; i < 260; i++) begin
            issue(32'hC000_0000);
            @(negedge clk);
            bus.rdy_spi = 1'b0;
            repeat (3) @(negedge clk);
        end
        #1;
        chk("sat_err", err_cnt, 255);
        chk("sat_cmd", cmd_cnt, 6);
        release_ack();

        issue(32'h4007_BEEF);
        @(negedge clk);
        bus.rdy_spi = 1'b0;
        @(negedge clk);
        bus.spi_busy = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_rst_push", bus.push_tx, 0);
        chk("pre_rst_reg7", cfg_regs[127:112], 32'hBEEF);
        chk("pre_rst_waddr", wr_addr, 7);
        chk("pre_rst_cmd", cmd_cnt, 7);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", bus.tx_input, 0);
        chk("arst_push", bus.push_tx, 0);
        chk("arst_ack", bus.ack_fetch_spi, 0);
        chk("arst_cmd", cmd_cnt, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_waddr", wr_addr, 0);
        chk("arst_reg0", cfg_regs[15:0], 32'hA5C3);
        chk("arst_regs", {31'd0, |cfg_regs[255:16]}, 0);
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        bus.spi_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_push", bus.push_tx, 0);
        chk("post_rst_ack", bus.ack_fetch_spi, 0);

        issue(32'h8007_0000);
        follow(32'h8007_0000, 0);
        chk("post_rst_cmd", cmd_cnt, 1);
        release_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
Command decoder and configuration register file that sits directly downstream of the SPI slave transceiver.
- Consumes each 32-bit received frame, qualified by the transceiver's single-cycle ready pulse.
- Executes WRITE/READ/NOP against a 16 x 16-bit register bank.
- Pushes a 32-bit response word back into the transceiver's TX holding register. The master clocks that word out during the next SPI frame.
- Returns the fetch acknowledge so the transceiver can return to idle.

Parameters:
LEN_SPI, 32, frame width; fixed at 32 by the frame format below
ADDR_W, 4, register address width
NUM_REGS, 16, number of registers (2**ADDR_W)
ID_VALUE, 16'hA5C3, read-only contents of register 0

Ports:
clk  in  1  chip clock, same clock as the SPI transceiver FSM side
rst_n  in  1  asynchronous reset, active low
rx_output  in  32  received frame from the transceiver
rdy_spi  in  1  one-clk pulse; rx_output is valid in that cycle
spi_busy  in  1  transceiver frame in progress
ack_fetch_spi  out  1  fetch acknowledge to the transceiver (level)
tx_input  out  32  response word to the transceiver
push_tx  out  1  one-clk load strobe for tx_input
cfg_regs  out  NUM_REGS*16  flat register image; reg i = bits [16i+15:16i]
wr_strobe  out  1  one-clk pulse on every successful register write
wr_addr  out  ADDR_W  address of the last successful write
cmd_cnt  out  8  count of accepted non-error commands; wraps at 255
err_cnt  out  8  count of error commands; saturates at 255

Behaviour:
Reset: all outputs 0, except register 0 reads ID_VALUE. All other registers are 0 and the FSM is in IDLE. Reset is asynchronous and may occur mid-operation; the FSM returns to IDLE with no partial push or acknowledge.

Frame format (rx_output):
- [31:30] op: 00 NOP, 01 WRITE, 10 READ, 11 reserved
- [29:16] addr field
- [15:0] data

Error conditions, evaluated in DECODE:
- op = 11
- addr field bits [29:16+ADDR_W] non-zero
- WRITE to address 0

Response word (tx_input):
- [31:30] op echo
- [29] err
- [28:16] addr field bits [28:16] echoed
- [15:0] payload:
  - READ, no error: register contents
  - WRITE: data actually written, or 0 on error
  - NOP or any error: 0

FSM states: IDLE, DECODE, EXEC, PUSH, WAIT_ACK.
- IDLE: when rdy_spi=1, latch rx_output into cmd_q and go to DECODE. All other cycles stay in IDLE.
- DECODE (1 clk): compute err and build the response.
- EXEC (1 clk):
  - WRITE with no error: update the register; pulse wr_strobe; set wr_addr.
  - Increment cmd_cnt if no error, otherwise increment err_cnt (saturating).
  - Go to PUSH.
- PUSH: hold tx_input stable. Assert push_tx for exactly one clk, in the first cycle where spi_busy=0, then go to WAIT_ACK. While spi_busy=1, wait with push_tx=0.
- WAIT_ACK:
  - Hold ack_fetch_spi=1.
  - Drop ack_fetch_spi and go to IDLE in the first cycle spi_busy=1 is seen (the transceiver has started a new frame).
  - If rdy_spi=1 arrives while in WAIT_ACK (transceiver re-entered the ready state directly), drop ack, latch the new frame and go to DECODE.
- rdy_spi while in DECODE/EXEC/PUSH: frame dropped, err_cnt incremented (overrun).

Latency and data rules:
- rdy_spi at cycle T produces wr_strobe at T+2 and push_tx at T+3 at the earliest.
- ack_fetch_spi rises at T+4.
- READ of an address written in the immediately preceding command returns the new value.
- A READ in the same command as a write is not possible (one op per frame).
- tx_input holds its last value outside PUSH.

Test Plan:
- Reset then frame 32'h8000_0000 (READ addr 0) -> push_tx once, tx_input = 32'h8000_A5C3, cmd_cnt=1, ack_fetch_spi high until spi_busy=1.
- WRITE frame 32'h4005_1234 -> wr_strobe pulse at T+2, wr_addr=5, cfg_regs[95:80]=16'h1234, tx_input=32'h4005_1234; then READ 32'h8005_0000 -> tx_input=32'h8005_1234.
- Error frames 32'h4000_FFFF (write reg 0), 32'hC003_0000 (op 11), 32'h8010_0000 (addr out of range) -> bit 29 set in each response, payload 0, registers unchanged, err_cnt=3, cmd_cnt unchanged.
- Hold spi_busy=1 during PUSH for 10 clks -> push_tx stays 0, tx_input stable; push_tx pulses in the first cycle after spi_busy falls.
- rdy_spi in WAIT_ACK with frame 32'h4002_00AA -> ack drops the same cycle, new command executes, reg2=16'h00AA. rdy_spi in EXEC -> frame ignored, err_cnt+1.
- 260 error frames -> err_cnt saturates at 255. Assert rst_n low mid-PUSH -> all outputs 0 immediately, reg0 reads ID_VALUE, FSM in IDLE.
